// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- registered valid/ready pipeline stage with a 2-entry skid buffer.
//
// Carries one opaque payload from one pipeline stage to the next. Both in_ready
// and out_valid are decoded from single state flops, so no combinational ready
// path crosses the stage. When nothing valid is held, out_data shows BUBBLE_VAL.
//
// Optional build macro: PIPE_STAGE_BUF_PERF_CNT_EN
//   defined   -> stall_cnt / bubble_cnt are saturating performance counters
//   undefined -> both counter ports are tied to 0 and no counter flops exist
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   flush      synchronous kill of all held entries
//   in_valid   upstream has a payload this cycle
//   in_ready   buffer can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data is a valid instruction
//   out_ready  downstream accepts this cycle
//   out_data   payload to next stage, BUBBLE_VAL when out_valid=0
//   stall_cnt  cycles with out_valid=1 and out_ready=0
//   bubble_cnt cycles with out_valid=0 and out_ready=1
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | main and skid invalid, main = BUBBLE_VAL
// ONE   | main valid, skid invalid
// TWO   | main and skid valid, input blocked

module pipe_stage_buf #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Encoding chosen so out_valid = state[0] and in_ready = ~state[1]:
    // each handshake output is a single flop, not a decode.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) state_d = ONE;
                end
                ONE: begin
                    if (in_fire && !out_ready) state_d = TWO;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                TWO: begin
                    if (out_fire) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid = state_q[0];
        in_ready  = ~state_q[1];
        out_data  = main_q;
    end

    // Payload registers. main is forced to BUBBLE_VAL whenever the buffer
    // drains, so out_data needs no mux against out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else if (flush) begin
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) main_q <= in_data;
                end
                ONE: begin
                    if (in_fire && out_ready) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        main_q <= BUBBLE_VAL;
                    end
                end
                TWO: begin
                    // Skid always drains into main before any newer input is
                    // taken, which keeps ordering strictly FIFO.
                    if (out_fire) begin
                        main_q <= skid_q;
                        skid_q <= BUBBLE_VAL;
                    end
                end
                default: begin
                    main_q <= BUBBLE_VAL;
                    skid_q <= BUBBLE_VAL;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Counters saturate rather than wrap and survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!out_valid && out_ready && (bubble_q != CNT_MAX)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed testbench for pipe_stage_buf. Inputs change 1 time unit after each
// rising edge; outputs are sampled at the same point, i.e. after the edge settles.

module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_checks;
    int n_fail;

    pipe_stage_buf #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL ('0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks valid/ready/data at the current sample point.
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h, want 0 1 0", out_valid, in_ready, out_data);
        end
        n_checks++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: stall=%0d bubble=%0d, want 0 0", stall_cnt, bubble_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h11) begin
            n_fail++;
            $display("FAIL mid_one: valid=%b ready=%b data=%h, want 1 1 11", out_valid, in_ready, out_data);
        end
        in_data = 32'h22;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h11) begin
            n_fail++;
            $display("FAIL mid_two: valid=%b ready=%b data=%h, want 1 0 11", out_valid, in_ready, out_data);
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_async_rst: valid=%b ready=%b data=%h, want 0 1 0", out_valid, in_ready, out_data);
        end
        n_checks++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_rst_cnt: stall=%0d bubble=%0d, want 0 0", stall_cnt, bubble_cnt);
        end
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_after_rst: valid=%b data=%h, want 0 0", out_valid, out_data);
        end
    endtask

    task automatic test_streaming();
        logic [DATA_W-1:0] vec [3];
        vec[0] = 32'h100; vec[1] = 32'h104; vec[2] = 32'h108;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vec[i];
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== vec[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b ready=%b data=%h, want 1 1 %h", i, out_valid, in_ready, out_data, vec[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_drain: valid=%b ready=%b data=%h, want 0 1 0", out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_two: valid=%b ready=%b data=%h, want 1 0 a", out_valid, in_ready, out_data);
        end
        // Newer payload offered while full must not overtake the skid entry.
        in_data = 32'hD;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b ready=%b data=%h, want 1 0 a", out_valid, in_ready, out_data);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'hB) begin
            n_fail++;
            $display("FAIL bp_pop1: valid=%b ready=%b data=%h, want 1 1 b", out_valid, in_ready, out_data);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hD) begin
            n_fail++;
            $display("FAIL bp_pop2: valid=%b data=%h, want 1 d", out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b data=%h, want 0 0", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1A;
        step();
        in_data = 32'h1B;
        step();
        flush = 1'b1; in_data = 32'hC;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_two: valid=%b ready=%b data=%h, want 0 1 0", out_valid, in_ready, out_data);
        end
        // in_fire coincident with flush (now in EMPTY) is discarded too.
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_empty_fire: valid=%b data=%h, want 0 0", out_valid, out_data);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_no_c: valid=%b data=%h, want 0 0", out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_empty_bubble();
        logic [CNT_W-1:0] exp_bub;
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                n_fail++;
                $display("FAIL bubble_%0d: valid=%b data=%h, want 0 0", i, out_valid, out_data);
            end
        end
        out_ready = 1'b0;
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
        exp_bub = 4'd3;
`else
        exp_bub = 4'd0;
`endif
        n_checks++;
        if (bubble_cnt !== exp_bub || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL bubble_cnt: bubble=%0d stall=%0d, want %0d 0", bubble_cnt, stall_cnt, exp_bub);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_10;
        logic [CNT_W-1:0] exp_sat;
        logic [CNT_W-1:0] exp_bub;
`ifdef PIPE_STAGE_BUF_PERF_CNT_EN
        exp_10 = 4'd10; exp_sat = 4'd15; exp_bub = 4'd3;
`else
        exp_10 = 4'd0; exp_sat = 4'd0; exp_bub = 4'd0;
`endif
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) begin
                n_checks++;
                if (stall_cnt !== exp_10) begin
                    n_fail++;
                    $display("FAIL stall_10: stall=%0d, want %0d", stall_cnt, exp_10);
                end
            end
        end
        n_checks++;
        if (stall_cnt !== exp_sat || out_data !== 32'h5 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_sat: stall=%0d data=%h valid=%b, want %0d 5 1", stall_cnt, out_data, out_valid, exp_sat);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_checks++;
        if (stall_cnt !== exp_sat || bubble_cnt !== exp_bub || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_after_flush: stall=%0d bubble=%0d valid=%b, want %0d %0d 0", stall_cnt, bubble_cnt, out_valid, exp_sat, exp_bub);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_reset_mid_stream();
        test_streaming();
        test_backpressure();
        test_flush();
        test_empty_bubble();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
